// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS control unit sequencing PC, IR, memory, register file and ALU selects
module mc_control_fsm #(
  parameter logic [5:0] OP_R    = 6'h00,
  parameter logic [5:0] OP_LW   = 6'h23,
  parameter logic [5:0] OP_SW   = 6'h2B,
  parameter logic [5:0] OP_BEQ  = 6'h04,
  parameter logic [5:0] OP_J    = 6'h02,
  parameter logic [5:0] OP_ADDI = 6'h08
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       jump,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  state_t cur;
  logic   op_legal;

  assign state = cur;

  // Opcodes the decoder knows how to sequence; anything else is flagged in DECODE
  assign op_legal = (opcode == OP_R) || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);

  // State sequencing; memory states hold until mem_ready, unused codes fall back to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= S_IDLE;
    end else begin
      case (cur)
        S_IDLE:      cur <= S_FETCH;
        S_FETCH:     if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          if (opcode == OP_LW || opcode == OP_SW) cur <= S_MEM_ADDR;
          else if (opcode == OP_R)                cur <= S_EXECUTE;
          else if (opcode == OP_BEQ)              cur <= S_BRANCH;
          else if (opcode == OP_J)                cur <= S_JUMP;
          else if (opcode == OP_ADDI)             cur <= S_ADDI_EXEC;
          else                                    cur <= S_FETCH;
        end
        S_MEM_ADDR:  cur <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (mem_ready) cur <= S_MEM_WB;
        S_MEM_WB:    cur <= S_FETCH;
        S_MEM_WRITE: if (mem_ready) cur <= S_FETCH;
        S_EXECUTE:   cur <= S_ALU_WB;
        S_ALU_WB:    cur <= S_FETCH;
        S_BRANCH:    cur <= S_FETCH;
        S_JUMP:      cur <= S_FETCH;
        S_ADDI_EXEC: cur <= S_ADDI_WB;
        S_ADDI_WB:   cur <= S_FETCH;
        default:     cur <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the current state, with the three input-gated strobes
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    illegal_op = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !op_legal;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        branch    = zero;
      end
      S_JUMP: begin
        jump = 1'b1;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed self-checking bench for mc_control_fsm
`timescale 1ns/1ps
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, branch, jump, ir_write, iord, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch(branch), .jump(jump), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_op(illegal_op), .state(state)
  );

  // Invariants checked on every sampled cycle of every program
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      vectors++;
      if ((32'(pc_write) + 32'(branch) + 32'(jump)) > 32'd1) begin
        errors++;
        $display("FAIL pc_strobes state=%0d pc_write=%b branch=%b jump=%b required at most one", state, pc_write, branch, jump);
      end
      vectors++;
      if ((mem_read & mem_write) !== 1'b0) begin
        errors++;
        $display("FAIL mem_excl state=%0d mem_read=%b mem_write=%b required not both", state, mem_read, mem_write);
      end
    end
  end

  task automatic step(input logic rdy, input logic z);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    zero      = z;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [17:0] outs;
    rst = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    outs = {pc_write, branch, jump, ir_write, iord, mem_read, mem_write, reg_write,
            reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal_op, 1'b0};
    vectors++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
    vectors++;
    if (outs !== 18'd0) begin errors++; $display("FAIL reset_outputs got=%h want=0", outs); end
    rst = 1'b0;
  endtask

  task automatic test_r_type;
    logic [3:0] exp_s  [5] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
    logic       exp_pc [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_rw [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 6'h00;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      vectors++;
      if (state !== exp_s[i]) begin errors++; $display("FAIL r_state[%0d] got=%0d want=%0d", i, state, exp_s[i]); end
      vectors++;
      if (pc_write !== exp_pc[i]) begin errors++; $display("FAIL r_pc_write[%0d] got=%b want=%b", i, pc_write, exp_pc[i]); end
      vectors++;
      if ({reg_write, reg_dst} !== {exp_rw[i], exp_rw[i]}) begin
        errors++; $display("FAIL r_reg_write_dst[%0d] got=%b%b want=%b%b", i, reg_write, reg_dst, exp_rw[i], exp_rw[i]);
      end
      if (i == 0) begin
        vectors++;
        if ({mem_read, iord, ir_write, alu_src_a, alu_src_b, alu_op} !== 8'b1010_0100) begin
          errors++; $display("FAIL fetch_selects got=%b want=10100100", {mem_read, iord, ir_write, alu_src_a, alu_src_b, alu_op});
        end
      end
      if (i == 2) begin
        vectors++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b1_00_10) begin
          errors++; $display("FAIL execute_selects got=%b want=10010", {alu_src_a, alu_src_b, alu_op});
        end
      end
    end
  endtask

  task automatic test_lw_stall;
    logic [3:0] exp_s [7] = '{4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 4'd1};
    logic       rdy   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    opcode = 6'h23;
    for (int i = 0; i < 7; i++) begin
      step(rdy[i], 1'b0);
      vectors++;
      if (state !== exp_s[i]) begin errors++; $display("FAIL lw_state[%0d] got=%0d want=%0d", i, state, exp_s[i]); end
      if (exp_s[i] == 4'd4) begin
        vectors++;
        if ({iord, mem_read} !== 2'b11) begin errors++; $display("FAIL lw_iord_read[%0d] got=%b%b want=11", i, iord, mem_read); end
      end
      if (exp_s[i] == 4'd5) begin
        vectors++;
        if ({reg_write, mem_to_reg, reg_dst} !== 3'b110) begin
          errors++; $display("FAIL lw_wb got=%b%b%b want=110", reg_write, mem_to_reg, reg_dst);
        end
      end
    end
  endtask

  task automatic test_sw_addi;
    logic [3:0] exp_sw [4] = '{4'd2, 4'd3, 4'd6, 4'd1};
    logic [3:0] exp_ad [4] = '{4'd2, 4'd11, 4'd12, 4'd1};
    opcode = 6'h2B;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      vectors++;
      if (state !== exp_sw[i]) begin errors++; $display("FAIL sw_state[%0d] got=%0d want=%0d", i, state, exp_sw[i]); end
    end
    opcode = 6'h08;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      vectors++;
      if (state !== exp_ad[i]) begin errors++; $display("FAIL addi_state[%0d] got=%0d want=%0d", i, state, exp_ad[i]); end
      if (i == 2) begin
        vectors++;
        if ({reg_write, reg_dst, mem_to_reg} !== 3'b100) begin
          errors++; $display("FAIL addi_wb got=%b%b%b want=100", reg_write, reg_dst, mem_to_reg);
        end
      end
    end
  endtask

  task automatic test_branch;
    logic [3:0] exp_s [3] = '{4'd2, 4'd9, 4'd1};
    opcode = 6'h04;
    for (int z = 1; z >= 0; z--) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b1, 1'(z));
        vectors++;
        if (state !== exp_s[i]) begin errors++; $display("FAIL beq_state z=%0d [%0d] got=%0d want=%0d", z, i, state, exp_s[i]); end
        vectors++;
        if (branch !== ((i == 1) && (z == 1))) begin
          errors++; $display("FAIL beq_branch z=%0d [%0d] got=%b want=%b", z, i, branch, ((i == 1) && (z == 1)));
        end
        if (i == 1) begin
          vectors++;
          if ({alu_src_a, alu_src_b, alu_op} !== 5'b1_00_01) begin
            errors++; $display("FAIL beq_selects got=%b want=10001", {alu_src_a, alu_src_b, alu_op});
          end
        end
      end
    end
    zero = 1'b1;
  endtask

  task automatic test_jump;
    logic [3:0] exp_s [3] = '{4'd2, 4'd10, 4'd1};
    logic       exp_j [3] = '{1'b0, 1'b1, 1'b0};
    opcode = 6'h02;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      vectors++;
      if (state !== exp_s[i]) begin errors++; $display("FAIL j_state[%0d] got=%0d want=%0d", i, state, exp_s[i]); end
      vectors++;
      if (jump !== exp_j[i]) begin errors++; $display("FAIL j_jump[%0d] got=%b want=%b", i, jump, exp_j[i]); end
    end
  endtask

  task automatic test_illegal;
    logic [3:0] exp_s  [2] = '{4'd2, 4'd1};
    logic       exp_il [2] = '{1'b1, 1'b0};
    opcode = 6'h3F;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1);
      vectors++;
      if (state !== exp_s[i]) begin errors++; $display("FAIL ill_state[%0d] got=%0d want=%0d", i, state, exp_s[i]); end
      vectors++;
      if (illegal_op !== exp_il[i]) begin errors++; $display("FAIL ill_pulse[%0d] got=%b want=%b", i, illegal_op, exp_il[i]); end
      vectors++;
      if ({reg_write, mem_write} !== 2'b00) begin errors++; $display("FAIL ill_no_write[%0d] got=%b%b want=00", i, reg_write, mem_write); end
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] exp_s [3] = '{4'd2, 4'd3, 4'd6};
    logic       rdy   [3] = '{1'b1, 1'b1, 1'b0};
    opcode = 6'h2B;
    for (int i = 0; i < 3; i++) begin
      step(rdy[i], 1'b0);
      vectors++;
      if (state !== exp_s[i]) begin errors++; $display("FAIL sw_rst_state[%0d] got=%0d want=%0d", i, state, exp_s[i]); end
    end
    vectors++;
    if (mem_write !== 1'b1) begin errors++; $display("FAIL sw_mem_write got=%b want=1", mem_write); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (state !== 4'd0) begin errors++; $display("FAIL async_rst_state got=%0d want=0", state); end
    vectors++;
    if (mem_write !== 1'b0) begin errors++; $display("FAIL async_rst_mem_write got=%b want=0", mem_write); end
    @(negedge clk);
    vectors++;
    if (state !== 4'd0) begin errors++; $display("FAIL rst_held_state got=%0d want=0", state); end
    mem_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (state !== 4'd1) begin errors++; $display("FAIL resume_fetch got=%0d want=1", state); end
  endtask

  initial begin
    test_reset;
    test_r_type;
    test_lw_stall;
    test_sw_addi;
    test_branch;
    test_jump;
    test_illegal;
    test_async_reset;
    test_jump;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle MIPS control unit that sequences the program counter, instruction register, memory port, register file and ALU muxes.
- Decodes a 6-bit opcode and drives the PC update strobes (`pc_write`, `branch`, `jump`) plus datapath selects, one instruction per 3–5 cycles.
- Uses a ready handshake to stall on slow memory.
- Sits between the instruction register and the datapath as the only source of PC update strobes.

Parameters:
- OP_R, 6'h00, R-type opcode
- OP_LW, 6'h23, load word opcode
- OP_SW, 6'h2B, store word opcode
- OP_BEQ, 6'h04, branch-equal opcode
- OP_J, 6'h02, jump opcode
- OP_ADDI, 6'h08, add-immediate opcode

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH completes
- zero  in  1  ALU zero flag; valid in BRANCH
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  PC loads PC+4 (`PCWriteValue` path)
- branch  out  1  PC adds branch offset
- jump  out  1  PC loads jump address
- ir_write  out  1  IR captures memory read data
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- reg_dst  out  1  write register select: 1=rd, 0=rt
- mem_to_reg  out  1  write data select: 1=MDR, 0=ALUOut
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, ALU_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12. Codes 13–15 go to IDLE on the next clock.
- Outputs are combinational decodes of `state` (Moore), except these gated terms:
  - FETCH: `pc_write` and `ir_write` gated by `mem_ready`.
  - BRANCH: `branch` gated by `zero`.
  - DECODE: `illegal_op` gated by the opcode decode.
- Unlisted outputs are 0 in every state.
- Reset: `rst`=1 forces `state`=IDLE immediately. Every output is 0 while in IDLE, `state` reads 0, and an operation cut off mid-way is abandoned.
- IDLE → FETCH unconditionally on the first clock after `rst` deasserts.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00.
  - `mem_ready`=0: stay in FETCH; `pc_write`=`ir_write`=0.
  - `mem_ready`=1: `pc_write`=`ir_write`=1, go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target precompute). Next state by opcode:
  - OP_LW or OP_SW → MEM_ADDR
  - OP_R → EXECUTE
  - OP_BEQ → BRANCH
  - OP_J → JUMP
  - OP_ADDI → ADDI_EXEC
  - any other opcode: `illegal_op`=1, → FETCH
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEM_READ if opcode is OP_LW, else MEM_WRITE.
- MEM_READ: `mem_read`=1, `iord`=1. Hold until `mem_ready`, then → MEM_WB.
- MEM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1 → FETCH.
- MEM_WRITE: `mem_write`=1, `iord`=1. Hold until `mem_ready`, then → FETCH.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10 → ALU_WB.
- ALU_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0 → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `branch`=`zero` → FETCH.
- JUMP: `jump`=1 → FETCH.
- ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00 → ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 → FETCH.
- PC strobes: at most one of `pc_write`/`branch`/`jump` is high in any cycle.
- Memory requests: `mem_read` and `mem_write` are never high together.
- Cycle counts with `mem_ready` held at 1, FETCH entry to next FETCH entry: R=4, LW=5, SW=4, BEQ=3, J=3, ADDI=4, illegal=2. Each cycle of `mem_ready`=0 in a memory state adds 1.
- `mem_ready` outside FETCH, MEM_READ and MEM_WRITE is ignored.
- `zero` outside BRANCH is ignored.

Test Plan:
- Reset then release, `mem_ready`=1, opcode=6'h00 → `state` sequence 0,1,2,7,8,1; `pc_write`=1 only in the FETCH cycle; `reg_write`=`reg_dst`=1 in ALU_WB.
- Opcode 6'h23, `mem_ready` low for 2 cycles in MEM_READ → states 1,2,3,4,4,4,5,1; `iord`=1 in state 4; `reg_write`=`mem_to_reg`=1 in state 5.
- Opcode 6'h04: `zero`=1 → `branch`=1 for one cycle in state 9; `zero`=0 → `branch`=0; both return to FETCH after 3 cycles.
- Opcode 6'h02 → `jump`=1 exactly one cycle in state 10. Over a full program of mixed opcodes, check `pc_write`+`branch`+`jump` ≤ 1 and `mem_read`&`mem_write`=0 every cycle.
- Opcode 6'h3F → `illegal_op` pulses for one cycle in DECODE, next state FETCH, no `reg_write` or `mem_write` asserted.
- Assert `rst` asynchronously mid-MEM_WRITE (`mem_ready`=0) → `state`=0 and `mem_write`=0 before the next clock edge; FETCH resumes on the first clock after release.
